// File: rtl/clock_pkg.sv
// Constants shared by the time-of-day counter chain.
// One modulus per time field, plus the BCD digit ceiling and a BCD-to-binary helper.
package clock_pkg;

    localparam int unsigned MOD_SEC  = 60;
    localparam int unsigned MOD_MIN  = 60;
    localparam int unsigned MOD_HOUR = 24;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Returns the numeric value of a two-digit BCD byte. Digits above 9 are not rejected here.
    function automatic int unsigned bcd_value(input logic [7:0] b);
        return 32'(b[7:4]) * 32'd10 + 32'(b[3:0]);
    endfunction

endpackage

// File: rtl/bcd2_step.sv
// Computes the next value of a two-digit BCD counter, stepping one count up or down.
// Also flags when the counter is at its terminal value for the current direction.
module bcd2_step
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS = 60
) (
    input  logic [7:0] q,
    input  logic       up,
    output logic [7:0] q_next,
    output logic       term
);

    localparam logic [3:0] TOP_T = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] TOP_O = 4'((MODULUS - 1) % 10);

    logic [3:0] tens;
    logic [3:0] ones;
    logic       at_top;
    logic       at_zero;

    assign tens    = q[7:4];
    assign ones    = q[3:0];
    assign at_top  = (q == {TOP_T, TOP_O});
    assign at_zero = (q == 8'h00);
    assign term    = up ? at_top : at_zero;

    // Digit carry and borrow assume the input value is valid.
    // The register in the parent module guarantees that.
    always_comb begin
        q_next = q;
        if (up) begin
            if (at_top)
                q_next = 8'h00;
            else if (ones == BCD_DIGIT_MAX)
                q_next = {tens + 4'd1, 4'd0};
            else
                q_next = {tens, ones + 4'd1};
        end else begin
            if (at_zero)
                q_next = {TOP_T, TOP_O};
            else if (ones == 4'd0)
                q_next = {tens - 4'd1, BCD_DIGIT_MAX};
            else
                q_next = {tens, ones - 4'd1};
        end
    end

endmodule

// File: rtl/mod_counter_n.sv
// Modulo-N up/down counter with binary or two-digit BCD output.
// Supports a checked parallel load and a combinational cascade carry.
module mod_counter_n
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 60,
    parameter bit          BCD     = 1'b1
) (
    input  logic             CP,
    input  logic             reset,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             LD_ERR
);

    logic [WIDTH-1:0] step_q;
    logic             term;
    logic             d_ok;

    generate
        if (BCD) begin : g_bcd
            bcd2_step #(.MODULUS(MODULUS)) u_step (
                .q      (Q[7:0]),
                .up     (UP),
                .q_next (step_q[7:0]),
                .term   (term)
            );

            assign d_ok = (D[7:4] <= BCD_DIGIT_MAX) && (D[3:0] <= BCD_DIGIT_MAX) &&
                          (bcd_value(D[7:0]) < MODULUS);
        end else begin : g_bin
            localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

            assign term   = UP ? (Q == QMAX) : (Q == '0);
            assign step_q = UP ? (term ? '0 : Q + 1'b1)
                               : (term ? QMAX : Q - 1'b1);
            assign d_ok   = (32'(D) < MODULUS);
        end
    endgenerate

    // Asserted on the cycle before the wrap edge, so the next stage advances on that same edge.
    assign CO = EN & ~LD & term;

    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            Q      <= '0;
            LD_ERR <= 1'b0;
        end else if (LD) begin
            Q      <= d_ok ? D : '0;
            LD_ERR <= ~d_ok;
        end else begin
            LD_ERR <= 1'b0;
            if (EN)
                Q <= step_q;
        end
    end

endmodule
